wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback-stage arbiter that produces the register-file write port: RegWrite, Write_register and Write_d.
It merges two result sources: ALU results, which have priority and are normally non-stalling, and load results from the LSU, which are buffered in a small FIFO.
It emits at most one registered write per cycle and exports a pending-destination mask for hazard detection in decode.
Writes to register 31 are discarded unless flagged as SP writes, which mirrors the XZR/SP read semantics.

Parameters:
LD_DEPTH, 4, load FIFO depth; power of 2, >=2
MAX_WAIT, 3, cycles a non-empty FIFO head may be bypassed by ALU results before the ALU is stalled for one cycle

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle
alu_rd  input  5  ALU destination register
alu_data  input  64  ALU result
alu_sp  input  1  rd==31 means SP (1) or XZR (0)
ld_valid  input  1  load result valid
ld_ready  output  1  FIFO can accept a load
ld_rd  input  5  load destination register
ld_data  input  64  load data
ld_sp  input  1  rd==31 means SP (1) or XZR (0)
RegWrite  output  1  register-file write enable (registered)
Write_register  output  5  register-file write index (registered)
Write_d  output  64  register-file write data (registered)
pending  output  32  one-hot OR of destinations not yet committed to the register file
fifo_count  output  log2(LD_DEPTH)+1  load FIFO occupancy

Behaviour:
- Reset (async, reset_n=0): FIFO empty, fifo_count=0, wait counter=0, RegWrite=0, Write_register=0, Write_d=0, pending=0. Entries in flight are dropped.
- Handshakes:
  - ld_fire = ld_valid & ld_ready.
  - ld_ready = (fifo_count < LD_DEPTH), combinational on state only. No push when full, even if a pop occurs the same cycle.
  - alu_fire = alu_valid & alu_ready.
  - alu_ready = !(fifo non-empty & wait_cnt == MAX_WAIT).
- Selection each cycle:
  - If alu_fire, the source is ALU.
  - Else if FIFO non-empty, the source is the FIFO head, which is popped.
  - Else no write.
- Same cycle push and pop on a non-empty FIFO is allowed; count is unchanged. The pointers wrap modulo LD_DEPTH.
- Starvation counter wait_cnt (states 0..MAX_WAIT):
  - 0 when FIFO empty or head popped.
  - Otherwise +1 per cycle the head is bypassed.
  - At MAX_WAIT the ALU stalls and the head pops; wait_cnt returns to 0.
- Output register, updated at the edge after selection:
  - RegWrite <= selected & !(rd==31 & !sp).
  - Write_register <= rd; Write_d <= data.
  - With no selection: RegWrite <= 0; Write_register and Write_d hold.
  - An XZR write is consumed (popped/accepted) but RegWrite stays 0.
- Latency:
  - ALU: RegWrite is high the cycle after alu_fire.
  - Load (no bypass): pushed at edge N, selected in cycle N+1 at the earliest, RegWrite high in cycle N+2.
- pending, combinational:
  - A bit is set for each valid FIFO entry whose write is effective (not XZR).
  - Plus bit Write_register when RegWrite=1, because the register file has not captured it until that edge.
  - Duplicate rd values OR together.
- The ALU never produces results out of order relative to itself. Order between ALU and loads is arbitration order.

Optional Feature:
WB_BYPASS_EN:
- Defined: if the FIFO is empty, alu_fire=0 and ld_fire=1, the load skips the FIFO and loads the output register at the same edge. RegWrite is high the cycle after ld_fire, and fifo_count stays 0.
- Undefined: all loads pass through the FIFO, with the 2-cycle latency above.

Test Plan:
1. alu_valid=1, alu_rd=3, alu_data=0xDEAD, one cycle -> next cycle RegWrite=1, Write_register=3, Write_d=0xDEAD; the following cycle RegWrite=0.
2. ALU rd=31, sp=0 -> RegWrite stays 0 and alu_ready=1. ALU rd=31, sp=1, data=0x8000 -> RegWrite=1, Write_register=31, Write_d=0x8000.
3. alu_valid=1 continuously with 5 back-to-back loads (rd 1..5), MAX_WAIT=3:
   - ld_ready=0 after 4 accepted.
   - alu_ready=0 exactly once every 4th cycle, with loads rd 1,2,3,4 written in order on those pulses.
   - The 5th load is accepted once a slot frees.
4. Load rd=5 accepted, no ALU traffic -> pending[5]=1 from the cycle after ld_fire through the RegWrite cycle, then 0. A load with rd=31, sp=0 never sets pending[31].
5. 3 loads queued, then reset_n pulsed low mid-cycle -> immediately fifo_count=0, pending=0, RegWrite=0. After release, no stale write is emitted.
6. With WB_BYPASS_EN, empty FIFO, a single load rd=7 data=0x42 -> RegWrite=1, Write_register=7, Write_d=0x42 one cycle after ld_fire, and fifo_count stays 0. Without the macro, the same write appears two cycles after ld_fire.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging ALU results and FIFO-buffered load results into one register-file write port
// Ports: clk/reset_n (async active-low); alu_valid/alu_ready/alu_rd/alu_data/alu_sp ALU result channel;
//   ld_valid/ld_ready/ld_rd/ld_data/ld_sp load result channel; RegWrite/Write_register/Write_d registered
//   write port; pending = destinations not yet in the register file; fifo_count = load FIFO occupancy.
// Optional: define WB_BYPASS_EN to let a load skip an empty FIFO straight into the output register.
module wb_arbiter #(
    parameter int LD_DEPTH = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_rd,
    input  logic [63:0]               alu_data,
    input  logic                      alu_sp,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [63:0]               ld_data,
    input  logic                      ld_sp,
    output logic                      RegWrite,
    output logic [4:0]                Write_register,
    output logic [63:0]               Write_d,
    output logic [31:0]               pending,
    output logic [$clog2(LD_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(LD_DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(LD_DEPTH);
    localparam logic [WW-1:0] WMAX  = WW'(MAX_WAIT);

    logic [4:0]          q_rd   [LD_DEPTH];
    logic [63:0]         q_data [LD_DEPTH];
    // Set only for live entries that really write (not XZR); doubles as the pending source.
    logic [LD_DEPTH-1:0] q_eff;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [WW-1:0]       wait_cnt;
    logic                empty, alu_fire, ld_fire, pop, push, byp, sel, sel_eff, ld_eff, alu_eff;
    logic [4:0]          sel_rd;
    logic [63:0]         sel_data;

    assign empty     = fifo_count == '0;
    assign ld_ready  = fifo_count < DEPTH;
    assign alu_ready = !(!empty && wait_cnt == WMAX);
    assign alu_fire  = alu_valid & alu_ready;
    assign ld_fire   = ld_valid & ld_ready;
    assign pop       = !alu_fire & !empty;
`ifdef WB_BYPASS_EN
    assign byp       = empty & !alu_fire & ld_fire;
`else
    assign byp       = 1'b0;
`endif
    assign push      = ld_fire & !byp;
    assign sel       = alu_fire | pop | byp;
    assign alu_eff   = !(alu_rd == 5'd31 && !alu_sp);
    assign ld_eff    = !(ld_rd == 5'd31 && !ld_sp);

    always_comb begin
        sel_rd   = alu_fire ? alu_rd   : pop ? q_rd[rd_ptr]   : ld_rd;
        sel_data = alu_fire ? alu_data : pop ? q_data[rd_ptr] : ld_data;
        sel_eff  = alu_fire ? alu_eff  : pop ? q_eff[rd_ptr]  : ld_eff;
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (q_eff[i]) pending[q_rd[i]] = 1'b1;
        // The register file captures Write_register only at the next edge.
        if (RegWrite) pending[Write_register] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= ld_rd;
            q_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            wait_cnt       <= '0;
            q_eff          <= '0;
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_d        <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                q_eff[wr_ptr] <= ld_eff;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                q_eff[rd_ptr] <= 1'b0;
            end
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
            // Counts only cycles where a waiting head loses to the ALU.
            wait_cnt   <= (empty | pop) ? '0 : wait_cnt + 1'b1;
            RegWrite   <= sel & sel_eff;
            if (sel) begin
                Write_register <= sel_rd;
                Write_d        <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter with a queue-level reference model
module tb_wb_arbiter;
    localparam int LD_DEPTH = 4;
    localparam int MAX_WAIT = 3;

    logic        clk = 0;
    logic        reset_n;
    logic        alu_valid, alu_sp, ld_valid, ld_sp;
    logic [4:0]  alu_rd, ld_rd;
    logic [63:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, RegWrite;
    logic [4:0]  Write_register;
    logic [63:0] Write_d;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad = 0;

    wb_arbiter #(.LD_DEPTH(LD_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data), .alu_sp(alu_sp),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data), .ld_sp(ld_sp),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_d(Write_d),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: load FIFO as a queue, starvation counter as an int.
    typedef struct packed {logic [4:0] rd; logic [63:0] d; logic eff;} ent_t;
    ent_t        q[$];
    ent_t        e;
    int          m_wait = 0;
    int          n;
    logic        m_rw = 0;
    logic [4:0]  m_wr = 0;
    logic [63:0] m_wd = 0;
    logic        alur, ldr, af, lf, byp;
    logic [31:0] pexp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_wait = 0;
            m_rw = 0;
            m_wr = 0;
            m_wd = 0;
        end else begin
            n = q.size();
            alur = !(n > 0 && m_wait == MAX_WAIT);
            ldr = n < LD_DEPTH;
            af = alu_valid && alur;
            lf = ld_valid && ldr;
            byp = 0;
            if (af) begin
                m_rw = !(alu_rd == 31 && !alu_sp);
                m_wr = alu_rd;
                m_wd = alu_data;
                m_wait = n > 0 ? m_wait + 1 : 0;
            end else if (n > 0) begin
                e = q.pop_front();
                m_rw = e.eff;
                m_wr = e.rd;
                m_wd = e.d;
                m_wait = 0;
            end
`ifdef WB_BYPASS_EN
            else if (lf) begin
                byp = 1;
                m_rw = !(ld_rd == 31 && !ld_sp);
                m_wr = ld_rd;
                m_wd = ld_data;
            end
`endif
            else m_rw = 0;
            if (n == 0) m_wait = 0;
            if (lf && !byp) q.push_back('{ld_rd, ld_data, !(ld_rd == 31 && !ld_sp)});
        end
    end

    always @(negedge clk) begin
        pexp = 0;
        foreach (q[i]) if (q[i].eff) pexp[q[i].rd] = 1;
        if (m_rw) pexp[m_wr] = 1;
        chk("m_RegWrite", 64'(RegWrite), 64'(m_rw));
        chk("m_Write_register", 64'(Write_register), 64'(m_wr));
        chk("m_Write_d", Write_d, m_wd);
        chk("m_pending", 64'(pending), 64'(pexp));
        chk("m_fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("m_alu_ready", 64'(alu_ready), 64'(!(q.size() > 0 && m_wait == MAX_WAIT)));
        chk("m_ld_ready", 64'(ld_ready), 64'(q.size() < LD_DEPTH));
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    int          nl, nw, first_full;
    logic [31:0] stall_mask, acc;
    logic [24:0] seq;
    logic [2:0]  p5;

    initial begin
        reset_n = 0;
        alu_valid = 0; alu_sp = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_sp = 0; ld_rd = 0; ld_data = 0;
        repeat (2) @(negedge clk);
        chk("reset RegWrite", 64'(RegWrite), 64'd0);
        chk("reset Write_register", 64'(Write_register), 64'd0);
        chk("reset Write_d", Write_d, 64'd0);
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset fifo_count", 64'(fifo_count), 64'd0);
        #2 reset_n = 1;
        tick;

        // ALU write, one-cycle latency
        alu_valid = 1; alu_rd = 3; alu_data = 64'hDEAD;
        tick;
        alu_valid = 0;
        @(negedge clk);
        chk("alu RegWrite", 64'(RegWrite), 64'd1);
        chk("alu Write_register", 64'(Write_register), 64'd3);
        chk("alu Write_d", Write_d, 64'hDEAD);
        tick;
        @(negedge clk);
        chk("alu RegWrite drop", 64'(RegWrite), 64'd0);

        // XZR vs SP on rd 31
        tick;
        alu_valid = 1; alu_rd = 31; alu_sp = 0; alu_data = 64'h5;
        @(negedge clk);
        chk("xzr alu_ready", 64'(alu_ready), 64'd1);
        tick;
        alu_sp = 1; alu_data = 64'h8000;
        @(negedge clk);
        chk("xzr RegWrite", 64'(RegWrite), 64'd0);
        tick;
        alu_valid = 0; alu_sp = 0;
        @(negedge clk);
        chk("sp RegWrite", 64'(RegWrite), 64'd1);
        chk("sp Write_register", 64'(Write_register), 64'd31);
        chk("sp Write_d", Write_d, 64'h8000);
        tick;

        // Continuous ALU traffic with five loads: starvation guard
        nl = 1; nw = 0; first_full = -1; stall_mask = 0; seq = 0;
        for (int c = 0; c < 24; c++) begin
            tick;
            alu_valid = 1; alu_rd = 10; alu_data = 64'hA000 + 64'(c);
            if (nl <= 5) begin
                ld_valid = 1; ld_rd = 5'(nl); ld_data = 64'h1000 + 64'(nl);
            end else ld_valid = 0;
            @(negedge clk);
            if (!alu_ready) stall_mask |= 32'(1) << c;
            if (!ld_ready && first_full < 0) first_full = c;
            if (RegWrite && Write_register != 5'd10) begin
                seq = {seq[19:0], Write_register};
                nw++;
            end
            if (ld_valid && ld_ready) nl++;
        end
        tick;
        alu_valid = 0; ld_valid = 0;
        chk("starve stall cycles", 64'(stall_mask), 64'h111110);
        chk("starve first full", 64'(first_full), 64'd4);
        chk("starve load writes", 64'(nw), 64'd5);
        chk("starve load order", 64'(seq), 64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5}));
        chk("starve all loads in", 64'(nl), 64'd6);
        tick;

        // pending tracks a load until its write is committed
        ld_valid = 1; ld_rd = 5; ld_sp = 0; ld_data = 64'h55;
        tick;
        ld_valid = 0;
        p5 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p5[k] = pending[5];
            tick;
        end
`ifdef WB_BYPASS_EN
        chk("pending[5] window", 64'(p5), 64'b001);
`else
        chk("pending[5] window", 64'(p5), 64'b011);
`endif
        ld_valid = 1; ld_rd = 31; ld_sp = 0;
        tick;
        ld_valid = 0;
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            acc |= {pending[31], 30'd0, RegWrite};
            tick;
        end
        chk("xzr load no pending/write", 64'(acc), 64'd0);

        // Reset with loads in flight
        alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
        ld_valid = 1; ld_rd = 20; ld_data = 64'h20;
        tick;
        ld_rd = 20; ld_data = 64'h21;
        tick;
        ld_rd = 22; ld_data = 64'h22;
        tick;
        ld_valid = 0;
        chk("pre-reset fifo_count", 64'(fifo_count), 64'd3);
        chk("pre-reset pending", 64'(pending), 64'h500200);
        #1 reset_n = 0; alu_valid = 0;
        #1;
        chk("async reset fifo_count", 64'(fifo_count), 64'd0);
        chk("async reset pending", 64'(pending), 64'd0);
        chk("async reset RegWrite", 64'(RegWrite), 64'd0);
        @(negedge clk);
        #2 reset_n = 1;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            acc |= {28'd0, fifo_count, RegWrite};
        end
        chk("no stale write after reset", 64'(acc), 64'd0);

        // Single load into an empty FIFO
        tick;
        ld_valid = 1; ld_rd = 7; ld_sp = 0; ld_data = 64'h42;
        tick;
        ld_valid = 0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("bypass RegWrite", 64'(RegWrite), 64'd1);
        chk("bypass Write_register", 64'(Write_register), 64'd7);
        chk("bypass Write_d", Write_d, 64'h42);
        chk("bypass fifo_count", 64'(fifo_count), 64'd0);
`else
        chk("load RegWrite early", 64'(RegWrite), 64'd0);
        chk("load fifo_count", 64'(fifo_count), 64'd1);
`endif
        tick;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("bypass RegWrite drop", 64'(RegWrite), 64'd0);
        chk("bypass fifo_count later", 64'(fifo_count), 64'd0);
`else
        chk("load RegWrite", 64'(RegWrite), 64'd1);
        chk("load Write_register", 64'(Write_register), 64'd7);
        chk("load Write_d", Write_d, 64'h42);
`endif
        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
